uart_tx_fifo_ctrl: RTL and testbench

Parametrised UART transmitter, successor to the fixed-format 8N1 transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. Frame format and baud divisor are configured at runtime, and consecutive frames are sent back-to-back with no idle gap. The block sits between the bus-side register/DMA logic and the TX pad.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_fifo_ctrl_if.sv | 11 +
 rtl/uart_tx_sync_fifo.sv | 52 +++++
 rtl/uart_tx_fifo_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM state and parity-mode definitions for the UART transmitter
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_tx_fifo_ctrl_if.sv
// rtl/uart_tx_fifo_ctrl_if.sv - valid/ready word handshake into the UART transmit FIFO
interface uart_tx_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_sync_fifo.sv
// rtl/uart_tx_sync_fifo.sv - synchronous FIFO with wrap-bit pointers, shared by the UART paths
module uart_tx_sync_fifo #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    // Extra MSB on each pointer distinguishes full from empty when the index bits match.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign count    = CW'(wr_ptr_q - rd_ptr_q);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// rtl/uart_tx_fifo_ctrl.sv - FIFO-fed UART transmitter, runtime frame format; UART_TX_FIFO_CTRL_PARITY_EN adds parity
module uart_tx_fifo_ctrl
    import uart_tx_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    parameter  int DIV_W  = 16,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_fifo_ctrl_if.slave in_if,
    input  logic [DIV_W-1:0]   cfg_baud_div,
    input  logic               cfg_stop2,
    input  logic [1:0]         cfg_parity,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done,
    output logic [CW-1:0]      fifo_count
);
    localparam int BW = $clog2(DATA_W + 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [DIV_W-1:0]  div_m1_q, div_m1_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fifo_pop, fifo_full, fifo_empty, load, bit_end;
    logic [DATA_W-1:0] fifo_head;
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
`else
    logic              unused_cfg_parity;
    assign unused_cfg_parity = ^cfg_parity;
`endif

    uart_tx_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_if.in_valid),
        .push_data (in_if.in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_if.in_ready = !fifo_full;
    assign bit_end        = (baud_cnt_q == div_m1_q);
    assign tx             = tx_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_W'(1);
        div_m1_d   = div_m1_q;
        bit_cnt_d  = bit_cnt_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        fifo_pop   = 1'b0;
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = '0;
                load       = !fifo_empty;
            end
            START: if (bit_end) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                tx_d      = shift_q[0];
            end
            DATA: if (bit_end) begin
                if (bit_cnt_q == BW'(DATA_W - 1)) begin
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d   = STOP;
                        tx_d      = 1'b1;
                        bit_cnt_d = '0;
                    end
`else
                    state_d   = STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    shift_d   = shift_q >> 1;
                    tx_d      = shift_q[1];
                end
            end
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
            PARITY: if (bit_end) begin
                state_d   = STOP;
                tx_d      = 1'b1;
                bit_cnt_d = '0;
            end
`endif
            // bit_cnt is reused to count the optional second stop bit.
            STOP: if (bit_end) begin
                if (stop2_q && bit_cnt_q == '0) begin
                    bit_cnt_d = BW'(1);
                end else begin
                    done_d = 1'b1;
                    load   = !fifo_empty;
                    if (fifo_empty) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: the format is captured here so mid-frame cfg changes are ignored.
        if (load) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_head;
            div_m1_d   = (cfg_baud_div == '0) ? '0 : cfg_baud_div - DIV_W'(1);
            stop2_d    = cfg_stop2;
            state_d    = START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            baud_cnt_d = '0;
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
            par_en_d   = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit_d  = (^fifo_head) ^ (cfg_parity == PAR_ODD);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            div_m1_q   <= '0;
            bit_cnt_q  <= '0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            div_m1_q   <= div_m1_d;
            bit_cnt_q  <= bit_cnt_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb/tb_uart_tx_fifo_ctrl.sv - directed self-checking bench for uart_tx_fifo_ctrl
module tb_uart_tx_fifo_ctrl;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int DIV_W  = 16;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIV_W-1:0] cfg_baud_div;
    logic             cfg_stop2;
    logic [1:0]       cfg_parity;
    logic             tx, tx_busy, tx_done;
    logic [2:0]       fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] words [6] = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'hC3, 8'h5A};

    uart_tx_fifo_ctrl_if #(.DATA_W(DATA_W)) in_if ();

    uart_tx_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_if        (in_if),
        .cfg_baud_div (cfg_baud_div),
        .cfg_stop2    (cfg_stop2),
        .cfg_parity   (cfg_parity),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic push(input logic [7:0] w);
        int n = 0;
        @(negedge clk);
        in_if.in_data  = w;
        in_if.in_valid = 1'b1;
        while (!in_if.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", 32'(in_if.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_if.in_valid = 1'b0;
    endtask

    // Samples one frame at negedges; gap = negedges waited before the start bit.
    task automatic frame(input int div, input int nb, output logic [15:0] bits,
                         output logic stable, output logic done_ok, output int gap);
        bits = '0; stable = 1'b1; done_ok = 1'b1; gap = 0;
        while (tx !== 1'b0 && gap < 2000) begin
            @(negedge clk);
            gap++;
        end
        if (tx !== 1'b0) begin
            done_ok = 1'b0;
            return;
        end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < div; c++) begin
                if (c == 0) bits[b[3:0]] = tx;
                else if (tx !== bits[b[3:0]]) stable = 1'b0;
                if (tx_done && (b != 0 || c != 0)) done_ok = 1'b0;
                @(negedge clk);
            end
        end
        if (tx_done !== 1'b1) done_ok = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] bits;
        logic        stable, done_ok;
        int          gap, lows, dones;

        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        cfg_baud_div   = 16'd4;
        cfg_stop2      = 1'b0;
        cfg_parity     = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_tx",       32'(tx), 1);
        check("rst_busy",     32'(tx_busy), 0);
        check("rst_done",     32'(tx_done), 0);
        check("rst_in_ready", 32'(in_if.in_ready), 1);
        check("rst_count",    32'(fifo_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Case 1: 8N1, div 4
        push(8'hA5);
        frame(4, 10, bits, stable, done_ok, gap);
        check("c1_bits",    32'(bits), 32'({1'b1, 8'hA5, 1'b0}));
        check("c1_stable",  32'(stable), 1);
        check("c1_done",    32'(done_ok), 1);
        check("c1_latency", gap, 1);
        check("c1_busy_end", 32'(tx_busy), 0);

        // Case 2: parity modes, div 2
        cfg_baud_div = 16'd2;
        cfg_parity   = 2'b01;
        push(8'hA5);
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
        frame(2, 11, bits, stable, done_ok, gap);
        check("c2_even_bits", 32'(bits), 32'({1'b1, 1'b0, 8'hA5, 1'b0}));
`else
        frame(2, 10, bits, stable, done_ok, gap);
        check("c2_even_bits", 32'(bits), 32'({1'b1, 8'hA5, 1'b0}));
`endif
        check("c2_even_done", 32'(done_ok & stable), 1);
        cfg_parity = 2'b10;
        push(8'hA5);
`ifdef UART_TX_FIFO_CTRL_PARITY_EN
        frame(2, 11, bits, stable, done_ok, gap);
        check("c2_odd_bits", 32'(bits), 32'({1'b1, 1'b1, 8'hA5, 1'b0}));
`else
        frame(2, 10, bits, stable, done_ok, gap);
        check("c2_odd_bits", 32'(bits), 32'({1'b1, 8'hA5, 1'b0}));
`endif
        check("c2_odd_done", 32'(done_ok & stable), 1);
        cfg_parity = 2'b11;
        push(8'hA5);
        frame(2, 10, bits, stable, done_ok, gap);
        check("c2_p11_bits", 32'(bits), 32'({1'b1, 8'hA5, 1'b0}));
        check("c2_p11_done", 32'(done_ok & stable), 1);

        // Case 3: two stop bits, div 3
        cfg_parity   = 2'b00;
        cfg_stop2    = 1'b1;
        cfg_baud_div = 16'd3;
        push(8'h00);
        frame(3, 11, bits, stable, done_ok, gap);
        check("c3_bits", 32'(bits), 32'({2'b11, 8'h00, 1'b0}));
        check("c3_done", 32'(done_ok & stable), 1);

        // Case 4: fill the FIFO while busy; frames must be back-to-back
        cfg_stop2    = 1'b0;
        cfg_baud_div = 16'd2;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(words[i]);
                    if (i == 4) begin
                        check("c4_full_count", 32'(fifo_count), 4);
                        check("c4_full_ready", 32'(in_if.in_ready), 0);
                    end
                end
            end
            begin
                logic [15:0] fb;
                logic        fs, fd;
                int          fg;
                for (int i = 0; i < 6; i++) begin
                    frame(2, 10, fb, fs, fd, fg);
                    check("c4_bits", 32'(fb), 32'({1'b1, words[i], 1'b0}));
                    check("c4_done", 32'(fs & fd), 1);
                    if (i > 0) check("c4_gap", fg, 0);
                end
                check("c4_busy_end", 32'(tx_busy), 0);
            end
        join

        // Case 5: div 0 acts as 1; a mid-frame divisor change is ignored
        cfg_baud_div = 16'd0;
        push(8'h5A);
        fork
            frame(1, 10, bits, stable, done_ok, gap);
            begin
                repeat (4) @(negedge clk);
                cfg_baud_div = 16'd7;
            end
        join
        check("c5_bits", 32'(bits), 32'({1'b1, 8'h5A, 1'b0}));
        check("c5_done", 32'(done_ok & stable), 1);
        push(8'h5A);
        frame(7, 10, bits, stable, done_ok, gap);
        check("c5_div7_bits", 32'(bits), 32'({1'b1, 8'h5A, 1'b0}));
        check("c5_div7_done", 32'(done_ok & stable), 1);

        // Case 6: reset in the middle of the data bits with two words queued
        cfg_baud_div = 16'd4;
        push(8'h00);
        push(8'h22);
        push(8'h33);
        check("c6_queued", 32'(fifo_count), 2);
        repeat (6) @(negedge clk);
        check("c6_pre_busy", 32'(tx_busy), 1);
        check("c6_pre_tx",   32'(tx), 0);
        rst_n = 1'b0;
        #1;
        check("c6_rst_tx",    32'(tx), 1);
        check("c6_rst_busy",  32'(tx_busy), 0);
        check("c6_rst_count", 32'(fifo_count), 0);
        check("c6_rst_ready", 32'(in_if.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (tx_done !== 1'b0) dones++;
        end
        check("c6_idle_tx",   lows, 0);
        check("c6_idle_done", dones, 0);
        check("c6_idle_busy", 32'(tx_busy), 0);
        push(8'hC3);
        frame(4, 10, bits, stable, done_ok, gap);
        check("c6_after_bits", 32'(bits), 32'({1'b1, 8'hC3, 1'b0}));
        check("c6_after_done", 32'(done_ok & stable), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
